// File: rtl/q_add.sv
// rtl/q_add.sv - signed-magnitude fixed-point adder, registered result, one-cycle done pulse (QADD_SATURATE_EN selects saturation on overflow)
module q_add #(
    parameter int Q = 23,
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] c,
    output logic         done_flag,
    output logic         overflow
);

    localparam int MW = N - 1;

    if (N <= Q + 1) begin : g_bad_params
        $error("q_add: N must be greater than Q + 1");
    end

    logic [N-1:0]  c_q, c_d;
    logic          done_flag_q, done_flag_d;
    logic          overflow_q, overflow_d;

    logic          sign_a, sign_b;
    logic [MW-1:0] mag_a, mag_b;
    logic [N-1:0]  sum_w;
    logic [MW-1:0] res_mag;
    logic          res_sign;
    logic          res_ovf;

    // Operand decode; a negative zero is folded to +0 so it never steers the result sign.
    always_comb begin
        mag_a  = a[N-2:0];
        mag_b  = b[N-2:0];
        sign_a = a[N-1] & (|a[N-2:0]);
        sign_b = b[N-1] & (|b[N-2:0]);
    end

    // Magnitude add or subtract, result sign, overflow and wrap/saturate handling.
    always_comb begin
        sum_w    = {1'b0, mag_a} + {1'b0, mag_b};
        res_mag  = '0;
        res_sign = 1'b0;
        res_ovf  = 1'b0;
        if (sign_a == sign_b) begin
            res_sign = sign_a;
            res_ovf  = sum_w[N-1];
            res_mag  = sum_w[N-2:0];
`ifdef QADD_SATURATE_EN
            if (res_ovf) begin
                res_mag = '1;
            end
`endif
        end else if (mag_a >= mag_b) begin
            res_sign = sign_a;
            res_mag  = mag_a - mag_b;
        end else begin
            res_sign = sign_b;
            res_mag  = mag_b - mag_a;
        end
        // A zero magnitude is always reported as +0.
        if (res_mag == '0) begin
            res_sign = 1'b0;
        end
    end

    // Next-state: load on start, otherwise hold the result and drop done.
    always_comb begin
        c_d         = c_q;
        overflow_d  = overflow_q;
        done_flag_d = 1'b0;
        if (start) begin
            c_d         = {res_sign, res_mag};
            overflow_d  = res_ovf;
            done_flag_d = 1'b1;
        end
    end

    // Result registers; reset wins over a same-edge start.
    always_ff @(posedge clk) begin
        if (rst) begin
            c_q         <= '0;
            done_flag_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            c_q         <= c_d;
            done_flag_q <= done_flag_d;
            overflow_q  <= overflow_d;
        end
    end

    assign c         = c_q;
    assign done_flag = done_flag_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_q_add.sv
// tb/tb_q_add.sv - self-checking bench for q_add: vector table, corner sequences, randomized model check
module tb_q_add;

    localparam int Q = 23;
    localparam int N = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [N-1:0]  a, b;
    logic [N-1:0]  c;
    logic          done_flag;
    logic          overflow;

    int n_cmp  = 0;
    int n_fail = 0;

    q_add #(.Q(Q), .N(N)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .c(c), .done_flag(done_flag), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_c;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Advance one edge and settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: signed integer sum of the two values, then re-encode.
    function automatic void model(input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] rc, output logic rovf);
        longint max_mag = (longint'(1) << (N - 1)) - 1;
        longint vx  = longint'(x[30:0]);
        longint vy  = longint'(y[30:0]);
        longint sum;
        longint mag;
        logic   neg;
        if (x[31]) vx = -vx;
        if (y[31]) vy = -vy;
        sum  = vx + vy;
        neg  = (sum < 0);
        mag  = neg ? -sum : sum;
        rovf = (mag > max_mag);
        if (rovf) begin
`ifdef QADD_SATURATE_EN
            mag = max_mag;
`else
            mag = mag % (max_mag + 1);
`endif
        end
        if (mag == 0) neg = 1'b0;
        rc = {neg, mag[30:0]};
    endfunction

    logic [31:0] exp_c;
    logic        exp_ovf;
    logic        exp_done;
    logic [31:0] ovf_c;

    initial begin
`ifdef QADD_SATURATE_EN
        ovf_c = 32'h7FFF_FFFF;
`else
        ovf_c = 32'h0000_0000;
`endif
        vecs[0] = '{32'h0080_0000, 32'h0040_0000, 32'h00C0_0000, 1'b0};
        vecs[1] = '{32'h8080_0000, 32'h8040_0000, 32'h80C0_0000, 1'b0};
        vecs[2] = '{32'h0080_0000, 32'h8040_0000, 32'h0040_0000, 1'b0};
        vecs[3] = '{32'h8080_0000, 32'h0040_0000, 32'h8040_0000, 1'b0};
        vecs[4] = '{32'h0080_0000, 32'h8080_0000, 32'h0000_0000, 1'b0};
        vecs[5] = '{32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b0};
        vecs[6] = '{32'h7FFF_FFFF, 32'h0000_0001, ovf_c,         1'b1};
        vecs[7] = '{32'h8000_0000, 32'h8000_0005, 32'h8000_0005, 1'b0};
        vecs[8] = '{32'h0000_0003, 32'h8000_0007, 32'h8000_0004, 1'b0};
        vecs[9] = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0};

        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        step(); step();
        chk("reset_c", c, 32'h0);
        chk("reset_done", {31'b0, done_flag}, 32'h0);
        chk("reset_ovf", {31'b0, overflow}, 32'h0);

        rst = 1'b0;
        a = 32'h1234_5678; b = 32'h0ABC_DEF0;
        step();
        a = 32'hFFFF_0000; b = 32'h7FFF_FFFF;
        step();
        chk("idle_c", c, 32'h0);
        chk("idle_done", {31'b0, done_flag}, 32'h0);
        chk("idle_ovf", {31'b0, overflow}, 32'h0);

        for (int i = 0; i < 10; i++) begin
            a = vecs[i].a; b = vecs[i].b; start = 1'b1;
            step();
            chk($sformatf("vec%0d_c", i), c, vecs[i].exp_c);
            chk($sformatf("vec%0d_ovf", i), {31'b0, overflow}, {31'b0, vecs[i].exp_ovf});
            chk($sformatf("vec%0d_done", i), {31'b0, done_flag}, 32'h1);
            start = 1'b0; a = ~a; b = ~b;
            step();
            chk($sformatf("vec%0d_done_drop", i), {31'b0, done_flag}, 32'h0);
            chk($sformatf("vec%0d_hold", i), c, vecs[i].exp_c);
        end

        for (int i = 1; i <= 3; i++) begin
            a = 32'(i) << Q; b = 32'(i) << Q; start = 1'b1;
            step();
            chk($sformatf("stream%0d_c", i), c, 32'(2 * i) << Q);
            chk($sformatf("stream%0d_done", i), {31'b0, done_flag}, 32'h1);
        end
        start = 1'b0;
        step();
        chk("stream_end_done", {31'b0, done_flag}, 32'h0);

        rst = 1'b1; start = 1'b1; a = 32'h0080_0000; b = 32'h0080_0000;
        step();
        chk("rst_start_c", c, 32'h0);
        chk("rst_start_done", {31'b0, done_flag}, 32'h0);
        rst = 1'b0;
        step();
        chk("launch_c", c, 32'h0100_0000);
        start = 1'b0; rst = 1'b1;
        step();
        chk("rst_after_c", c, 32'h0);
        chk("rst_after_done", {31'b0, done_flag}, 32'h0);
        rst = 1'b0;
        step();
        chk("rst_after_idle_done", {31'b0, done_flag}, 32'h0);

        exp_c = '0; exp_ovf = 1'b0; exp_done = 1'b0;
        for (int i = 0; i < 300; i++) begin
            logic [31:0] rc;
            logic        rovf;
            a = $urandom; b = $urandom;
            if ($urandom_range(0, 3) == 0) a[30:27] = 4'hF;
            if ($urandom_range(0, 3) == 0) b[30:27] = 4'hF;
            if ($urandom_range(0, 7) == 0) b = {~a[31], a[30:0]};
            if ($urandom_range(0, 9) == 0) a[30:0] = '0;
            start = ($urandom_range(0, 9) < 7);
            if (start) begin
                model(a, b, rc, rovf);
                exp_c = rc; exp_ovf = rovf; exp_done = 1'b1;
            end else begin
                exp_done = 1'b0;
            end
            step();
            chk($sformatf("rand%0d_c", i), c, exp_c);
            chk($sformatf("rand%0d_ovf", i), {31'b0, overflow}, {31'b0, exp_ovf});
            chk($sformatf("rand%0d_done", i), {31'b0, done_flag}, {31'b0, exp_done});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
